rr_encoder4_2: RTL

Registered 4:2 round-robin request encoder. It is the inverse of the 2:4 enabled decoder: it takes up to four one-hot request lines, picks one winner, and presents the winner as a 2-bit index with a valid/ready handshake. It sits ahead of register-file and bus-select paths, so the same 2:4 decoder can regenerate the one-hot select downstream. The grant is held stable until it is consumed, and the priority pointer rotates so that no requester is starved.

---
 rtl/rr_encoder4_2.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rr_encoder4_2.sv
// rr_encoder4_2: registered 4:2 round-robin request encoder.
//
// Picks one winner from up to four level-sensitive request lines and presents
// it as a 2-bit index (plus its one-hot decode) behind a valid/ready handshake.
// A presented grant is held stable until it is consumed. With ROUND_ROBIN = 1
// the search start rotates to one past the last consumed grant, so no
// requester starves. With ROUND_ROBIN = 0 the lowest set index always wins.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   en         - enable for new grants; a held grant is never cancelled by it
//   req[3:0]   - request lines, any combination
//   out_ready  - consumer accepts the presented grant this cycle
//   out_valid  - a grant is being presented
//   out_sel    - encoded index of the granted request
//   out_onehot - decode(out_sel) while out_valid, otherwise zero
//
// All outputs come straight from registers.

module rr_encoder4_2 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] out_sel,
    output logic [3:0] out_onehot
);

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] onehot_q, onehot_d;

    logic       transfer;
    logic [1:0] search_ptr;
    logic [1:0] win_idx;
    logic       win_found;

    assign transfer = (state_q == StHold) && out_ready;

    // On a transfer the next winner is searched from the already-updated
    // pointer, so back-to-back grants rotate without a bubble.
    always_comb begin
        search_ptr = ptr_q;
        if (transfer && ROUND_ROBIN) begin
            search_ptr = sel_q + 2'd1;
        end
    end

    // Scan upward from search_ptr, wrapping 3 -> 0; the first set bit wins.
    always_comb begin
        logic [1:0] idx;
        win_idx   = 2'd0;
        win_found = 1'b0;
        idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = search_ptr + 2'(i);
            if (!win_found && req[idx]) begin
                win_idx   = idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        onehot_d = onehot_q;

        unique case (state_q)
            StIdle: begin
                if (en && win_found) begin
                    sel_d    = win_idx;
                    onehot_d = 4'b0001 << win_idx;
                    state_d  = StHold;
                end
            end
            StHold: begin
                // Without out_ready everything stays frozen, even if req drops.
                if (out_ready) begin
                    if (ROUND_ROBIN) begin
                        ptr_d = sel_q + 2'd1;
                    end
                    if (en && win_found) begin
                        sel_d    = win_idx;
                        onehot_d = 4'b0001 << win_idx;
                    end else begin
                        // out_sel keeps its last value; only onehot clears.
                        onehot_d = 4'b0000;
                        state_d  = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ptr_q    <= 2'd0;
            sel_q    <= 2'd0;
            onehot_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
        end
    end

    assign out_valid  = (state_q == StHold);
    assign out_sel    = sel_q;
    assign out_onehot = onehot_q;

endmodule
